// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared Gray/binary conversion helpers and width limit for gray_counter.
package gray_pkg;

  localparam int GRAY_MAX_WIDTH = 16;

  typedef logic [GRAY_MAX_WIDTH-1:0] gray_word_t;

  // Inputs narrower than GRAY_MAX_WIDTH are zero-extended; callers truncate the result.
  function automatic gray_word_t bin2gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic gray_word_t gray2bin(input gray_word_t g);
    gray_word_t b;
    b[GRAY_MAX_WIDTH-1] = g[GRAY_MAX_WIDTH-1];
    for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_dec.sv
// rtl/gray2bin_dec.sv - combinational WIDTH-bit Gray-to-binary XOR-chain decoder.
module gray2bin_dec
  import gray_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] bin_out
);

  always_comb begin
    bin_out = '0;
    bin_out[WIDTH-1] = gray_in[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      bin_out[i] = bin_out[i+1] ^ gray_in[i];
    end
  end

endmodule

// File: rtl/gray_counter.sv
// rtl/gray_counter.sv - up/down Gray-code counter with Gray load and terminal-count/wrap flags.
// Define GRAY_CNT_SAT_EN to saturate at the end of the range instead of wrapping.
module gray_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] load_bin;

  gray2bin_dec #(
    .WIDTH(WIDTH)
  ) u_load_dec (
    .gray_in(load_gray),
    .bin_out(load_bin)
  );

  assign tc = up ? (bin_q == CNT_MAX) : (bin_q == '0);

  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (load) begin
      bin_d = load_bin;
    end else if (en) begin
`ifdef GRAY_CNT_SAT_EN
      if (!tc) begin
        bin_d = up ? bin_q + WIDTH'(1) : bin_q - WIDTH'(1);
      end
`else
      bin_d  = up ? bin_q + WIDTH'(1) : bin_q - WIDTH'(1);
      wrap_d = tc;
`endif
    end
    // Gray register is loaded from the next binary value so both views change together.
    gray_d = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(bin_d)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bin_out  = bin_q;
  assign gray_out = gray_q;
  assign wrap     = wrap_q;

endmodule
